// File: rtl/data_memory_pipeline_pkg.sv
// Shared types for the data-memory pipeline: load funct3 codes,
// per-slot control bundle and the bubble constant.
package data_memory_pipeline_pkg;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_type_e;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       is_load;
    logic [2:0] load_type;
  } slot_ctrl_t;

  localparam slot_ctrl_t BUBBLE_SLOT = '0;

endpackage

// File: rtl/data_memory_pipeline_load_data_aligner.sv
// Load data aligner: picks byte/half/word from a cache word by offset.
// Ports: i_word, i_offset[1:0], i_load_type[2:0] in; o_data out.
module load_data_aligner
  import data_memory_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [1:0]            i_offset,
  input  logic [2:0]            i_load_type,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_word[{i_offset[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_word;
    unique case (1'b1)
      (i_load_type == LT_LB):
        o_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      (i_load_type == LT_LBU):
        o_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      (i_load_type == LT_LH):
        o_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      (i_load_type == LT_LHU):
        o_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default:
        o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory_pipeline.sv
// DM1->DM2->DM3->WB pipeline with load-use and cache-miss stalls.
// Ports: EX bundle + cache data in; DMn/WB forwarding taps, stalls out.
module data_memory_pipeline
  import data_memory_pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADD_WIDTH = 5
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EX_VALID,
  input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_EX,
  input  logic                     RD_WRITE_ENABLE_EX,
  input  logic [DATA_WIDTH-1:0]    ALU_RESULT_EX,
  input  logic                     IS_LOAD_EX,
  input  logic [2:0]               LOAD_TYPE_EX,
  input  logic [REG_ADD_WIDTH-1:0] RS1_ADDRESS_EX,
  input  logic [REG_ADD_WIDTH-1:0] RS2_ADDRESS_EX,
  input  logic                     DATA_CACHE_HIT,
  input  logic [DATA_WIDTH-1:0]    DATA_CACHE_DATA,
  output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM1,
  output logic                     RD_WRITE_ENABLE_DM1,
  output logic [DATA_WIDTH-1:0]    RD_DATA_DM1,
  output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM2,
  output logic                     RD_WRITE_ENABLE_DM2,
  output logic [DATA_WIDTH-1:0]    RD_DATA_DM2,
  output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_DM3,
  output logic                     RD_WRITE_ENABLE_DM3,
  output logic [DATA_WIDTH-1:0]    RD_DATA_DM3,
  output logic [REG_ADD_WIDTH-1:0] RD_ADDRESS_WB,
  output logic                     RD_WRITE_ENABLE_WB,
  output logic [DATA_WIDTH-1:0]    RD_DATA_WB,
  output logic                     STALL_EXECUTION_STAGE,
  output logic                     STALL_DATA_MEMORY
);

  slot_ctrl_t               r_ctrl [3];
  logic [REG_ADD_WIDTH-1:0] r_rd   [3];
  logic [DATA_WIDTH-1:0]    r_data [3];

  logic                     r_wb_en;
  logic [REG_ADD_WIDTH-1:0] r_wb_rd;
  logic [DATA_WIDTH-1:0]    r_wb_data;

  logic                     w_dm_stall;
  logic                     w_load_use;
  logic [1:0]               w_hazard;
  logic                     w_en [3];
  logic [REG_ADD_WIDTH-1:0] w_addr [3];
  logic [DATA_WIDTH-1:0]    w_aligned;
  logic [DATA_WIDTH-1:0]    w_dm3_data;

  load_data_aligner #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_word      (DATA_CACHE_DATA),
    .i_offset    (r_data[2][1:0]),
    .i_load_type (r_ctrl[2].load_type),
    .o_data      (w_aligned)
  );

  assign w_dm_stall = r_ctrl[2].valid
                    & r_ctrl[2].is_load
                    & ~DATA_CACHE_HIT;

  // Loads in DM1/DM2 have no data yet; a dependent EX must wait.
  always_comb begin
    w_hazard = '0;
    for (int i = 0; i < 2; i++) begin
      w_hazard[i] = r_ctrl[i].valid
                  & r_ctrl[i].is_load
                  & (|r_rd[i])
                  & ((r_rd[i] == RS1_ADDRESS_EX)
                   | (r_rd[i] == RS2_ADDRESS_EX));
    end
  end

  assign w_load_use = EX_VALID & (|w_hazard);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_addr[i] = r_ctrl[i].valid ? r_rd[i] : '0;
    end
    w_en[0] = r_ctrl[0].valid & r_ctrl[0].we
            & (|r_rd[0]) & ~r_ctrl[0].is_load;
    w_en[1] = r_ctrl[1].valid & r_ctrl[1].we
            & (|r_rd[1]) & ~r_ctrl[1].is_load;
    w_en[2] = r_ctrl[2].valid & r_ctrl[2].we
            & (|r_rd[2])
            & (~r_ctrl[2].is_load | DATA_CACHE_HIT);
  end

  always_comb begin
    w_dm3_data = '0;
    if (r_ctrl[2].valid) begin
      w_dm3_data = r_ctrl[2].is_load ? w_aligned
                                     : r_data[2];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        r_ctrl[i] <= BUBBLE_SLOT;
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (w_dm_stall) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en   <= w_en[2];
      r_wb_rd   <= w_addr[2];
      r_wb_data <= w_dm3_data;
      r_ctrl[2] <= r_ctrl[1];
      r_rd[2]   <= r_rd[1];
      r_data[2] <= r_data[1];
      r_ctrl[1] <= r_ctrl[0];
      r_rd[1]   <= r_rd[0];
      r_data[1] <= r_data[0];
      if (EX_VALID && !w_load_use) begin
        r_ctrl[0] <= '{valid:     1'b1,
                       we:        RD_WRITE_ENABLE_EX,
                       is_load:   IS_LOAD_EX,
                       load_type: LOAD_TYPE_EX};
        r_rd[0]   <= RD_ADDRESS_EX;
        r_data[0] <= ALU_RESULT_EX;
      end else begin
        r_ctrl[0] <= BUBBLE_SLOT;
        r_rd[0]   <= '0;
        r_data[0] <= '0;
      end
    end
  end

  assign RD_ADDRESS_DM1        = w_addr[0];
  assign RD_WRITE_ENABLE_DM1   = w_en[0];
  assign RD_DATA_DM1           = r_ctrl[0].valid ? r_data[0] : '0;
  assign RD_ADDRESS_DM2        = w_addr[1];
  assign RD_WRITE_ENABLE_DM2   = w_en[1];
  assign RD_DATA_DM2           = r_ctrl[1].valid ? r_data[1] : '0;
  assign RD_ADDRESS_DM3        = w_addr[2];
  assign RD_WRITE_ENABLE_DM3   = w_en[2];
  assign RD_DATA_DM3           = w_dm3_data;
  assign RD_ADDRESS_WB         = r_wb_rd;
  assign RD_WRITE_ENABLE_WB    = r_wb_en;
  assign RD_DATA_WB            = r_wb_data;
  assign STALL_DATA_MEMORY     = w_dm_stall;
  assign STALL_EXECUTION_STAGE = w_dm_stall | w_load_use;

endmodule

// File: tb/tb_data_memory_pipeline.sv
// Directed bench for data_memory_pipeline.
// Hand-computed vectors for forwarding, stalls, alignment, reset.
module tb_data_memory_pipeline;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EX_VALID;
  logic [4:0]  RD_ADDRESS_EX;
  logic        RD_WRITE_ENABLE_EX;
  logic [31:0] ALU_RESULT_EX;
  logic        IS_LOAD_EX;
  logic [2:0]  LOAD_TYPE_EX;
  logic [4:0]  RS1_ADDRESS_EX;
  logic [4:0]  RS2_ADDRESS_EX;
  logic        DATA_CACHE_HIT;
  logic [31:0] DATA_CACHE_DATA;
  logic [4:0]  RD_ADDRESS_DM1, RD_ADDRESS_DM2;
  logic [4:0]  RD_ADDRESS_DM3, RD_ADDRESS_WB;
  logic        RD_WRITE_ENABLE_DM1, RD_WRITE_ENABLE_DM2;
  logic        RD_WRITE_ENABLE_DM3, RD_WRITE_ENABLE_WB;
  logic [31:0] RD_DATA_DM1, RD_DATA_DM2;
  logic [31:0] RD_DATA_DM3, RD_DATA_WB;
  logic        STALL_EXECUTION_STAGE;
  logic        STALL_DATA_MEMORY;

  int n_tot = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  data_memory_pipeline dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .EX_VALID              (EX_VALID),
    .RD_ADDRESS_EX         (RD_ADDRESS_EX),
    .RD_WRITE_ENABLE_EX    (RD_WRITE_ENABLE_EX),
    .ALU_RESULT_EX         (ALU_RESULT_EX),
    .IS_LOAD_EX            (IS_LOAD_EX),
    .LOAD_TYPE_EX          (LOAD_TYPE_EX),
    .RS1_ADDRESS_EX        (RS1_ADDRESS_EX),
    .RS2_ADDRESS_EX        (RS2_ADDRESS_EX),
    .DATA_CACHE_HIT        (DATA_CACHE_HIT),
    .DATA_CACHE_DATA       (DATA_CACHE_DATA),
    .RD_ADDRESS_DM1        (RD_ADDRESS_DM1),
    .RD_WRITE_ENABLE_DM1   (RD_WRITE_ENABLE_DM1),
    .RD_DATA_DM1           (RD_DATA_DM1),
    .RD_ADDRESS_DM2        (RD_ADDRESS_DM2),
    .RD_WRITE_ENABLE_DM2   (RD_WRITE_ENABLE_DM2),
    .RD_DATA_DM2           (RD_DATA_DM2),
    .RD_ADDRESS_DM3        (RD_ADDRESS_DM3),
    .RD_WRITE_ENABLE_DM3   (RD_WRITE_ENABLE_DM3),
    .RD_DATA_DM3           (RD_DATA_DM3),
    .RD_ADDRESS_WB         (RD_ADDRESS_WB),
    .RD_WRITE_ENABLE_WB    (RD_WRITE_ENABLE_WB),
    .RD_DATA_WB            (RD_DATA_WB),
    .STALL_EXECUTION_STAGE (STALL_EXECUTION_STAGE),
    .STALL_DATA_MEMORY     (STALL_DATA_MEMORY)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic ex_set(input logic v, input logic [4:0] rd,
                        input logic we, input logic [31:0] alu,
                        input logic ld, input logic [2:0] lt,
                        input logic [4:0] rs1,
                        input logic [4:0] rs2);
    EX_VALID           = v;
    RD_ADDRESS_EX      = rd;
    RD_WRITE_ENABLE_EX = we;
    ALU_RESULT_EX      = alu;
    IS_LOAD_EX         = ld;
    LOAD_TYPE_EX       = lt;
    RS1_ADDRESS_EX     = rs1;
    RS2_ADDRESS_EX     = rs2;
  endtask

  task automatic ex_off;
    ex_set(1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 3'd0, 5'd0, 5'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dm1"}, {27'd0, RD_ADDRESS_DM1} |
        {31'd0, RD_WRITE_ENABLE_DM1} | RD_DATA_DM1, 32'd0);
    chk({tag, ".dm2"}, {27'd0, RD_ADDRESS_DM2} |
        {31'd0, RD_WRITE_ENABLE_DM2} | RD_DATA_DM2, 32'd0);
    chk({tag, ".dm3"}, {27'd0, RD_ADDRESS_DM3} |
        {31'd0, RD_WRITE_ENABLE_DM3} | RD_DATA_DM3, 32'd0);
    chk({tag, ".wb"}, {27'd0, RD_ADDRESS_WB} |
        {31'd0, RD_WRITE_ENABLE_WB} | RD_DATA_WB, 32'd0);
    chk({tag, ".stall"}, {30'd0, STALL_EXECUTION_STAGE,
        STALL_DATA_MEMORY}, 32'd0);
  endtask

  logic [2:0]  al_lt  [6] = '{3'b000, 3'b100, 3'b001,
                              3'b101, 3'b010, 3'b011};
  logic [31:0] al_adr [6] = '{32'h1003, 32'h1003, 32'h1002,
                              32'h1002, 32'h1003, 32'h1001};
  logic [31:0] al_exp [6] = '{32'hFFFF_FF80, 32'h0000_0080,
                              32'hFFFF_80FF, 32'h0000_80FF,
                              32'h80FF_0000, 32'h80FF_0000};

  initial begin
    RST             = 1'b1;
    DATA_CACHE_HIT  = 1'b1;
    DATA_CACHE_DATA = 32'd0;
    ex_off();
    tick();
    RST = 1'b0;
    #1;
    chk_all_zero("reset");

    // ALU op x5 = 0x12 walks DM1..WB
    ex_set(1'b1, 5'd5, 1'b1, 32'h12, 1'b0, 3'd0, 5'd0, 5'd0);
    tick();
    ex_off();
    #1;
    chk("alu.dm1.en", {31'd0, RD_WRITE_ENABLE_DM1}, 32'd1);
    chk("alu.dm1.rd", {27'd0, RD_ADDRESS_DM1}, 32'd5);
    chk("alu.dm1.d", RD_DATA_DM1, 32'h12);
    tick();
    chk("alu.dm2.en", {31'd0, RD_WRITE_ENABLE_DM2}, 32'd1);
    chk("alu.wb.pre", {31'd0, RD_WRITE_ENABLE_WB}, 32'd0);
    tick();
    chk("alu.dm3.d", RD_DATA_DM3, 32'h12);
    chk("alu.dm3.en", {31'd0, RD_WRITE_ENABLE_DM3}, 32'd1);
    tick();
    chk("alu.wb.en", {31'd0, RD_WRITE_ENABLE_WB}, 32'd1);
    chk("alu.wb.rd", {27'd0, RD_ADDRESS_WB}, 32'd5);
    chk("alu.wb.d", RD_DATA_WB, 32'h12);

    // load-use: LW x7 followed by consumer of x7
    DATA_CACHE_DATA = 32'h0000_ABCD;
    ex_set(1'b1, 5'd7, 1'b1, 32'h100, 1'b1, 3'b010, 5'd0, 5'd0);
    tick();
    ex_set(1'b1, 5'd8, 1'b1, 32'h55, 1'b0, 3'd0, 5'd7, 5'd3);
    #1;
    chk("lu.stall0", {31'd0, STALL_EXECUTION_STAGE}, 32'd1);
    chk("lu.dmst0", {31'd0, STALL_DATA_MEMORY}, 32'd0);
    chk("lu.dm1.en", {31'd0, RD_WRITE_ENABLE_DM1}, 32'd0);
    tick();
    chk("lu.stall1", {31'd0, STALL_EXECUTION_STAGE}, 32'd1);
    chk("lu.bub1", {27'd0, RD_ADDRESS_DM1}, 32'd0);
    chk("lu.dm2.rd", {27'd0, RD_ADDRESS_DM2}, 32'd7);
    tick();
    chk("lu.stall2", {31'd0, STALL_EXECUTION_STAGE}, 32'd0);
    chk("lu.bub2", {27'd0, RD_ADDRESS_DM1}, 32'd0);
    chk("lu.dm3.en", {31'd0, RD_WRITE_ENABLE_DM3}, 32'd1);
    chk("lu.dm3.d", RD_DATA_DM3, 32'h0000_ABCD);
    tick();
    ex_off();
    #1;
    chk("lu.adv.rd", {27'd0, RD_ADDRESS_DM1}, 32'd8);
    chk("lu.adv.d", RD_DATA_DM1, 32'h55);
    chk("lu.wb.rd", {27'd0, RD_ADDRESS_WB}, 32'd7);
    chk("lu.wb.d", RD_DATA_WB, 32'h0000_ABCD);
    tick();
    tick();
    tick();

    // alignment table against one cache word
    DATA_CACHE_DATA = 32'h80FF_0000;
    for (int i = 0; i < 6; i++) begin
      ex_set(1'b1, 5'd9, 1'b1, al_adr[i], 1'b1, al_lt[i],
             5'd0, 5'd0);
      tick();
      ex_off();
      tick();
      tick();
      chk($sformatf("align%0d", i), RD_DATA_DM3, al_exp[i]);
    end
    tick();

    // cache miss for 3 cycles with ALU op x11 behind the load
    DATA_CACHE_HIT = 1'b0;
    ex_set(1'b1, 5'd10, 1'b1, 32'h200, 1'b1, 3'b010, 5'd0, 5'd0);
    tick();
    ex_set(1'b1, 5'd11, 1'b1, 32'h77, 1'b0, 3'd0, 5'd0, 5'd0);
    tick();
    ex_off();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("miss%0d.dmst", k),
          {31'd0, STALL_DATA_MEMORY}, 32'd1);
      chk($sformatf("miss%0d.exst", k),
          {31'd0, STALL_EXECUTION_STAGE}, 32'd1);
      chk($sformatf("miss%0d.dm3", k),
          {27'd0, RD_ADDRESS_DM3}, 32'd10);
      chk($sformatf("miss%0d.dm2", k),
          {27'd0, RD_ADDRESS_DM2}, 32'd11);
      chk($sformatf("miss%0d.en3", k),
          {31'd0, RD_WRITE_ENABLE_DM3}, 32'd0);
      chk($sformatf("miss%0d.wb", k),
          {31'd0, RD_WRITE_ENABLE_WB}, 32'd0);
      tick();
    end
    DATA_CACHE_HIT  = 1'b1;
    DATA_CACHE_DATA = 32'h1234_5678;
    #1;
    chk("hit.dmst", {31'd0, STALL_DATA_MEMORY}, 32'd0);
    chk("hit.en3", {31'd0, RD_WRITE_ENABLE_DM3}, 32'd1);
    tick();
    chk("hit.wb.en", {31'd0, RD_WRITE_ENABLE_WB}, 32'd1);
    chk("hit.wb.rd", {27'd0, RD_ADDRESS_WB}, 32'd10);
    chk("hit.wb.d", RD_DATA_WB, 32'h1234_5678);
    chk("hit.dm3", {27'd0, RD_ADDRESS_DM3}, 32'd11);
    tick();
    tick();

    // load to x0 and consumer of x0: no stall, no writes
    ex_set(1'b1, 5'd0, 1'b1, 32'h300, 1'b1, 3'b010, 5'd0, 5'd0);
    tick();
    ex_set(1'b1, 5'd0, 1'b1, 32'h44, 1'b0, 3'd0, 5'd0, 5'd0);
    #1;
    chk("x0.stall", {31'd0, STALL_EXECUTION_STAGE}, 32'd0);
    tick();
    ex_off();
    #1;
    chk("x0.en1", {31'd0, RD_WRITE_ENABLE_DM1}, 32'd0);
    chk("x0.en2", {31'd0, RD_WRITE_ENABLE_DM2}, 32'd0);
    tick();
    chk("x0.en3", {31'd0, RD_WRITE_ENABLE_DM3}, 32'd0);
    tick();
    chk("x0.wb", {31'd0, RD_WRITE_ENABLE_WB}, 32'd0);
    tick();
    tick();

    // reset in the middle of a miss
    DATA_CACHE_HIT = 1'b0;
    ex_set(1'b1, 5'd12, 1'b1, 32'h400, 1'b1, 3'b010, 5'd0, 5'd0);
    tick();
    ex_off();
    tick();
    tick();
    chk("rmiss.dmst", {31'd0, STALL_DATA_MEMORY}, 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk_all_zero("rmiss");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_pipeline.md
DATA_MEMORY_PIPELINE -- requirements
Module: data_memory_pipeline

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be:
  - DATA_WIDTH, default 32, data path width.
  - REG_ADD_WIDTH, default 5, register address width.
REQ-003 Ports SHALL be (name  direction  width  meaning):
  - CLK  in  1  clock.
  - RST  in  1  synchronous active-high reset.
  - EX_VALID  in  1  execution stage holds a real instruction.
  - RD_ADDRESS_EX  in  REG_ADD_WIDTH  destination register.
  - RD_WRITE_ENABLE_EX  in  1  instruction writes rd.
  - ALU_RESULT_EX  in  DATA_WIDTH  ALU result or load address.
  - IS_LOAD_EX  in  1  instruction is a load.
  - LOAD_TYPE_EX  in  3  funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - RS1_ADDRESS_EX, RS2_ADDRESS_EX  in  REG_ADD_WIDTH  sources of the instruction in EX.
  - DATA_CACHE_HIT  in  1  read data valid for the load in DM3.
  - DATA_CACHE_DATA  in  DATA_WIDTH  word read for the DM3 load.
  - RD_ADDRESS_DMn / RD_WRITE_ENABLE_DMn / RD_DATA_DMn (n=1,2,3), RD_ADDRESS_WB / RD_WRITE_ENABLE_WB / RD_DATA_WB  out  REG_ADD_WIDTH / 1 / DATA_WIDTH  forwarding taps and register-file write port.
  - STALL_EXECUTION_STAGE  out  1  execution stage and all earlier stages SHALL hold.
  - STALL_DATA_MEMORY  out  1  DM1..DM3 frozen on a cache miss.

Function
REQ-004 Four registered slots, DM1->DM2->DM3->WB, each holding: valid, rd, we, is_load, load_type, data.
REQ-005 dm_stall SHALL be (DM3 valid & is_load & ~DATA_CACHE_HIT), combinationally; STALL_DATA_MEMORY = dm_stall.
REQ-006 load_use SHALL be high when DM1 or DM2 holds a valid load with rd != 0 and rd equal to RS1_ADDRESS_EX or RS2_ADDRESS_EX, qualified by EX_VALID.
REQ-007 STALL_EXECUTION_STAGE SHALL be dm_stall | load_use, combinational in the same cycle.
REQ-008 When dm_stall is high, DM1..DM3 SHALL hold their contents, and WB SHALL load a bubble (valid=0).
REQ-009 When dm_stall is low, DM2<=DM1, DM3<=DM2 and WB<=DM3, with DM3 data replaced per REQ-011.
  - DM1 SHALL capture EX when load_use is low; otherwise DM1 SHALL capture a bubble.
REQ-010 RD_WRITE_ENABLE outputs:
  - DM1 and DM2: valid & we & (rd != 0) & ~is_load.
  - DM3: valid & we & (rd != 0) & (~is_load | DATA_CACHE_HIT).
  - WB: the registered enable.
  - A bubble SHALL drive enable 0, address 0 and data 0.
REQ-011 RD_DATA_DM3 SHALL equal the aligned load data for a load, otherwise the ALU result; WB SHALL register this value.
REQ-012 Alignment SHALL use the stored address bits [1:0]:
  - Byte: select byte [1:0]*8; LB sign-extends, LBU zero-extends.
  - Halfword: select the half at bit [1]*16; LH sign-extends, LHU zero-extends.
  - LW: the full word; bits [1:0] are ignored.
  - Unlisted funct3 values SHALL behave as LW.
REQ-013 Latency: an ALU result is visible at DM1 one cycle after capture and at WB four cycles after capture, absent stalls.

Reset
REQ-014 RST high at a clock edge SHALL clear every slot's valid, rd, we, is_load, load_type and data to 0, including mid-miss.
REQ-015 With all slots cleared by reset, all outputs SHALL be 0 in the following cycle.
REQ-016 No state SHALL survive reset.

Structure
REQ-017 LOAD_TYPE encodings and a bubble-slot constant SHALL live in the shared pipeline package.
REQ-018 Alignment SHALL be one combinational sub-module, LOAD_DATA_ALIGNER (inputs: word, offset, load_type; output: aligned word).

Verification
REQ-019 ALU op x5=0x12 captured with no stalls -> DM1 tap en=1 at cycle+1, WB en=1 data=0x12 at cycle+4.
REQ-020 Load x7 in DM1 while EX has RS1=7 -> STALL_EXECUTION_STAGE=1 for 2 cycles, two bubbles enter DM1, then the EX instruction advances.
REQ-021 LB at address offset 3, cache word 0x80FF_0000, hit -> RD_DATA_DM3=0xFFFF_FF80; same case as LBU -> 0x0000_0080.
REQ-022 Load in DM3 with DATA_CACHE_HIT=0 for 3 cycles -> DM slots frozen, WB en=0 for 3 cycles, load written on the hit cycle +1.
REQ-023 Load with rd=x0 and load_use check with rd=x0 -> no stall and no write enable anywhere.
REQ-024 RST asserted during a miss -> all outputs 0 the next cycle, and stalls deasserted.
